// File: rtl/race_state_controller.sv
// Game-flow controller for the two-player racer: start countdown, lap
// counting from checkpoint/finish-line regions, winner/draw detection
// and a saturating race timer for the HUD.
module race_state_controller #(
  parameter int unsigned TICK_CYCLES = 100000000,
  parameter int unsigned LAPS_TO_WIN = 3,
  parameter logic [9:0]  FIN_X0      = 10'd5,
  parameter logic [9:0]  FIN_X1      = 10'd40,
  parameter logic [9:0]  FIN_Y0      = 10'd115,
  parameter logic [9:0]  FIN_Y1      = 10'd120,
  parameter logic [9:0]  CHK_X0      = 10'd280,
  parameter logic [9:0]  CHK_X1      = 10'd315,
  parameter logic [9:0]  CHK_Y0      = 10'd115,
  parameter logic [9:0]  CHK_Y1      = 10'd135,
  parameter logic [9:0]  TIME_MAX    = 10'd999
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [9:0] p1_pos_x_i,
  input  logic [9:0] p1_pos_y_i,
  input  logic [9:0] p2_pos_x_i,
  input  logic [9:0] p2_pos_y_i,
  output logic [2:0] state_o,
  output logic [1:0] countdown_o,
  output logic [2:0] p1_lap_o,
  output logic [2:0] p2_lap_o,
  output logic [9:0] race_time_o,
  output logic       state_changed_o
);

  localparam int unsigned TW = $clog2(TICK_CYCLES);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [2:0] LAPS_WIN = 3'(LAPS_TO_WIN);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    COUNT  = 3'd1,
    GO     = 3'd2,
    RACING = 3'd4,
    P1_WIN = 3'd5,
    P2_WIN = 3'd6,
    DRAW   = 3'd7
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tickCnt_q, tickCnt_d;
  logic [1:0]    countdown_q, countdown_d;
  logic [2:0]    p1Lap_q, p1Lap_d, p2Lap_q, p2Lap_d;
  logic [9:0]    raceTime_q, raceTime_d;
  logic          p1Armed_q, p1Armed_d, p2Armed_q, p2Armed_d;
  logic          changed_q;
  logic [9:0]    p1X_q, p1Y_q, p2X_q, p2Y_q;
  logic          p1InChkPrev_q, p1InFinPrev_q, p2InChkPrev_q, p2InFinPrev_q;

  logic tick;
  logic p1InChk, p1InFin, p2InChk, p2InFin;
  logic p1ChkRise, p1FinRise, p2ChkRise, p2FinRise;

  assign tick = (tickCnt_q == TICK_LAST);

  assign p1InFin = (p1X_q >= FIN_X0) && (p1X_q <= FIN_X1) && (p1Y_q >= FIN_Y0) && (p1Y_q <= FIN_Y1);
  assign p1InChk = (p1X_q >= CHK_X0) && (p1X_q <= CHK_X1) && (p1Y_q >= CHK_Y0) && (p1Y_q <= CHK_Y1);
  assign p2InFin = (p2X_q >= FIN_X0) && (p2X_q <= FIN_X1) && (p2Y_q >= FIN_Y0) && (p2Y_q <= FIN_Y1);
  assign p2InChk = (p2X_q >= CHK_X0) && (p2X_q <= CHK_X1) && (p2Y_q >= CHK_Y0) && (p2Y_q <= CHK_Y1);

  assign p1ChkRise = p1InChk && !p1InChkPrev_q;
  assign p1FinRise = p1InFin && !p1InFinPrev_q;
  assign p2ChkRise = p2InChk && !p2InChkPrev_q;
  assign p2FinRise = p2InFin && !p2InFinPrev_q;

  // Next-state, countdown, lap/arm and timer logic; IDLE entry wipes race data
  always_comb begin
    state_d     = state_q;
    countdown_d = countdown_q;
    p1Lap_d     = p1Lap_q;
    p2Lap_d     = p2Lap_q;
    raceTime_d  = raceTime_q;
    p1Armed_d   = p1Armed_q;
    p2Armed_d   = p2Armed_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d     = COUNT;
          countdown_d = 2'd3;
        end
      end
      COUNT: begin
        if (tick) begin
          if (countdown_q == 2'd1) begin
            state_d     = GO;
            countdown_d = 2'd0;
          end else begin
            countdown_d = countdown_q - 2'd1;
          end
        end
      end
      GO: begin
        if (tick) state_d = RACING;
      end
      RACING: begin
        if (tick && (raceTime_q < TIME_MAX)) raceTime_d = raceTime_q + 10'd1;
        if (p1ChkRise) p1Armed_d = 1'b1;
        if (p1FinRise && p1Armed_q) begin
          p1Lap_d   = p1Lap_q + 3'd1;
          p1Armed_d = 1'b0;
        end
        if (p2ChkRise) p2Armed_d = 1'b1;
        if (p2FinRise && p2Armed_q) begin
          p2Lap_d   = p2Lap_q + 3'd1;
          p2Armed_d = 1'b0;
        end
        if ((p1Lap_d == LAPS_WIN) && (p2Lap_d == LAPS_WIN)) state_d = DRAW;
        else if (p1Lap_d == LAPS_WIN)                      state_d = P1_WIN;
        else if (p2Lap_d == LAPS_WIN)                      state_d = P2_WIN;
      end
      P1_WIN, P2_WIN, DRAW: begin
        if (start_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d == IDLE) begin
      countdown_d = 2'd0;
      p1Lap_d     = 3'd0;
      p2Lap_d     = 3'd0;
      raceTime_d  = 10'd0;
      p1Armed_d   = 1'b0;
      p2Armed_d   = 1'b0;
    end

    if ((state_d != state_q) || tick) tickCnt_d = '0;
    else                              tickCnt_d = tickCnt_q + TW'(1);
  end

  // State and race registers, plus the one-cycle transition pulse
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      tickCnt_q   <= '0;
      countdown_q <= 2'd0;
      p1Lap_q     <= 3'd0;
      p2Lap_q     <= 3'd0;
      raceTime_q  <= 10'd0;
      p1Armed_q   <= 1'b0;
      p2Armed_q   <= 1'b0;
      changed_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tickCnt_q   <= tickCnt_d;
      countdown_q <= countdown_d;
      p1Lap_q     <= p1Lap_d;
      p2Lap_q     <= p2Lap_d;
      raceTime_q  <= raceTime_d;
      p1Armed_q   <= p1Armed_d;
      p2Armed_q   <= p2Armed_d;
      changed_q   <= (state_d != state_q);
    end
  end

  // Position pipeline stage and in-box history used for edge detection
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      p1X_q         <= 10'd0;
      p1Y_q         <= 10'd0;
      p2X_q         <= 10'd0;
      p2Y_q         <= 10'd0;
      p1InChkPrev_q <= 1'b0;
      p1InFinPrev_q <= 1'b0;
      p2InChkPrev_q <= 1'b0;
      p2InFinPrev_q <= 1'b0;
    end else begin
      p1X_q         <= p1_pos_x_i;
      p1Y_q         <= p1_pos_y_i;
      p2X_q         <= p2_pos_x_i;
      p2Y_q         <= p2_pos_y_i;
      p1InChkPrev_q <= p1InChk;
      p1InFinPrev_q <= p1InFin;
      p2InChkPrev_q <= p2InChk;
      p2InFinPrev_q <= p2InFin;
    end
  end

  assign state_o         = state_q;
  assign countdown_o     = countdown_q;
  assign p1_lap_o        = p1Lap_q;
  assign p2_lap_o        = p2Lap_q;
  assign race_time_o     = raceTime_q;
  assign state_changed_o = changed_q;

endmodule

// File: tb/tb_race_state_controller.sv
// Self-checking bench for race_state_controller: directed race scenarios
// followed by randomized driving, compared against a behavioural model.
module tb_race_state_controller;

  localparam int TICK = 4;
  localparam int LAPS = 2;
  localparam int TMAX = 5;

  logic       clk = 1'b0;
  logic       rstN;
  logic       start;
  logic [9:0] p1x, p1y, p2x, p2y;
  logic [2:0] state;
  logic [1:0] countdown;
  logic [2:0] p1Lap, p2Lap;
  logic [9:0] raceTime;
  logic       stateChanged;

  race_state_controller #(
    .TICK_CYCLES(TICK),
    .LAPS_TO_WIN(LAPS),
    .TIME_MAX(10'(TMAX))
  ) dut (
    .clk_i(clk),
    .rst_ni(rstN),
    .start_i(start),
    .p1_pos_x_i(p1x),
    .p1_pos_y_i(p1y),
    .p2_pos_x_i(p2x),
    .p2_pos_y_i(p2y),
    .state_o(state),
    .countdown_o(countdown),
    .p1_lap_o(p1Lap),
    .p2_lap_o(p2Lap),
    .race_time_o(raceTime),
    .state_changed_o(stateChanged)
  );

  // Free-running 100 MHz-style clock
  always #5 clk = ~clk;

  int checksTotal  = 0;
  int checksPassed = 0;

  int posX[2];
  int posY[2];

  // Behavioural reference: state code, cycles spent in the current state,
  // per-player lap bookkeeping over the previous cycle's positions.
  int mState;
  int mElapsed;
  int mCountdown;
  int mLap[2];
  int mTime;
  bit mChanged;
  bit mArmed[2];
  bit mPrevFin[2];
  bit mPrevChk[2];
  int mRegX[2];
  int mRegY[2];

  function automatic bit inBox(input int x, input int y, input int x0, input int x1,
                               input int y0, input int y1);
    return (x >= x0) && (x <= x1) && (y >= y0) && (y <= y1);
  endfunction

  task automatic modelReset();
    mState = 0; mElapsed = 0; mCountdown = 0; mTime = 0; mChanged = 0;
    for (int p = 0; p < 2; p++) begin
      mLap[p] = 0; mArmed[p] = 0; mPrevFin[p] = 0; mPrevChk[p] = 0;
      mRegX[p] = 0; mRegY[p] = 0;
    end
  endtask

  task automatic modelStep(input bit st);
    int nxt;
    int e;
    bit fin[2];
    bit chk[2];
    nxt = mState;
    e   = mElapsed + 1;
    for (int p = 0; p < 2; p++) begin
      fin[p] = inBox(mRegX[p], mRegY[p], 5, 40, 115, 120);
      chk[p] = inBox(mRegX[p], mRegY[p], 280, 315, 115, 135);
    end
    case (mState)
      0: if (st) begin nxt = 1; mCountdown = 3; end
      1: begin
        if (e >= 3 * TICK) begin nxt = 2; mCountdown = 0; end
        else mCountdown = 3 - e / TICK;
      end
      2: if (e >= TICK) nxt = 4;
      4: begin
        mTime = (e / TICK > TMAX) ? TMAX : e / TICK;
        for (int p = 0; p < 2; p++) begin
          if (chk[p] && !mPrevChk[p]) mArmed[p] = 1;
          if (fin[p] && !mPrevFin[p] && mArmed[p]) begin
            mLap[p]++;
            mArmed[p] = 0;
          end
        end
        if (mLap[0] >= LAPS && mLap[1] >= LAPS) nxt = 7;
        else if (mLap[0] >= LAPS)               nxt = 5;
        else if (mLap[1] >= LAPS)               nxt = 6;
      end
      default: if (st) nxt = 0;
    endcase
    for (int p = 0; p < 2; p++) begin
      mPrevFin[p] = fin[p];
      mPrevChk[p] = chk[p];
      mRegX[p]    = posX[p];
      mRegY[p]    = posY[p];
    end
    if (nxt == 0) begin
      mTime = 0;
      for (int p = 0; p < 2; p++) begin mLap[p] = 0; mArmed[p] = 0; end
    end
    mChanged = (nxt != mState);
    mElapsed = mChanged ? 0 : e;
    mState   = nxt;
  endtask

  // Single comparison point: counts and reports any mismatch
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checksTotal++;
    if (observed == expected) checksPassed++;
    else $display("[TB] FAIL %s: observed %0d, expected %0d at %0t", tag, observed, expected, $time);
  endtask

  task automatic checkAll();
    checkOutput("state", int'(state), mState);
    checkOutput("countdown", int'(countdown), mCountdown);
    checkOutput("p1Lap", int'(p1Lap), mLap[0]);
    checkOutput("p2Lap", int'(p2Lap), mLap[1]);
    checkOutput("raceTime", int'(raceTime), mTime);
    checkOutput("stateChanged", int'(stateChanged), int'(mChanged));
  endtask

  task automatic applyStimulus(input bit st);
    @(negedge clk);
    start = st;
    p1x = 10'(posX[0]); p1y = 10'(posY[0]);
    p2x = 10'(posX[1]); p2y = 10'(posY[1]);
    @(posedge clk);
    modelStep(st);
    #1 checkAll();
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0);
  endtask

  task automatic setPos(input int p, input int x, input int y);
    posX[p] = x;
    posY[p] = y;
  endtask

  task automatic waitForState(input int target, input string tag);
    int budget;
    budget = 60;
    while (int'(state) != target && budget > 0) begin
      applyStimulus(1'b0);
      budget--;
    end
    checkOutput(tag, int'(state), target);
  endtask

  // Reset is dropped between clock edges and checked before the next edge
  task automatic asyncReset();
    @(negedge clk);
    start = 1'b0;
    #2 rstN = 1'b0;
    #1 modelReset();
    checkAll();
    @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic pickPoint(input int p);
    int kind;
    int xs[4];
    int ys[4];
    kind = $urandom_range(0, 3);
    case (kind)
      0: setPos(p, $urandom_range(5, 40), $urandom_range(115, 120));
      1: setPos(p, $urandom_range(280, 315), $urandom_range(115, 135));
      2: setPos(p, $urandom_range(0, 1023), $urandom_range(0, 1023));
      default: begin
        if ($urandom_range(0, 1) == 0) begin
          xs = '{4, 5, 40, 41};  ys = '{114, 115, 120, 121};
        end else begin
          xs = '{279, 280, 315, 316};  ys = '{114, 115, 135, 136};
        end
        setPos(p, xs[$urandom_range(0, 3)], ys[$urandom_range(0, 3)]);
      end
    endcase
  endtask

  int savedTime;

  initial begin
    rstN  = 1'b0;
    start = 1'b0;
    setPos(0, 15, 117);
    setPos(1, 20, 118);
    p1x = 10'd15; p1y = 10'd117; p2x = 10'd20; p2y = 10'd118;
    modelReset();
    #12 checkAll();
    @(negedge clk);
    rstN = 1'b1;

    // Countdown sequence with an ignored start pulse mid-count
    runCycles(2);
    applyStimulus(1'b1);
    checkOutput("countdownStart", int'(countdown), 3);
    runCycles(5);
    applyStimulus(1'b1);
    waitForState(4, "reachRacing");

    // Lap gating: re-entering the line unarmed never counts
    setPos(0, 15, 100); runCycles(2);
    setPos(0, 15, 117); runCycles(2);
    checkOutput("noLapUnarmed", int'(p1Lap), 0);
    applyStimulus(1'b1);
    setPos(0, 300, 125); runCycles(2);
    setPos(0, 15, 117);
    applyStimulus(1'b0);
    checkOutput("lapNotYet", int'(p1Lap), 0);
    applyStimulus(1'b0);
    checkOutput("lapAfterLatency", int'(p1Lap), 1);

    // P2 completes two laps while P1 sits on one
    for (int l = 0; l < 2; l++) begin
      setPos(1, 300, 125); runCycles(2);
      setPos(1, 20, 118);  runCycles(2);
    end
    checkOutput("p2Wins", int'(state), 6);
    savedTime = mTime;
    runCycles(10);
    checkOutput("p2LapFrozen", int'(p2Lap), 2);
    checkOutput("timeFrozen", int'(raceTime), savedTime);
    applyStimulus(1'b1);
    checkOutput("idleAfterWin", int'(state), 0);
    checkOutput("lapsCleared", int'(p1Lap) + int'(p2Lap), 0);

    // Draw: both players cross armed on the same cycle
    applyStimulus(1'b1);
    waitForState(4, "reachRacingDraw");
    for (int l = 0; l < 2; l++) begin
      setPos(0, 300, 125); setPos(1, 310, 130); runCycles(2);
      setPos(0, 15, 117);  setPos(1, 20, 118);  runCycles(2);
    end
    checkOutput("draw", int'(state), 7);

    // Timer saturation over a long race
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    waitForState(4, "reachRacingTimer");
    runCycles(8 * TICK + 2);
    checkOutput("timeSaturated", int'(raceTime), TMAX);
    runCycles(8);
    checkOutput("timeHeld", int'(raceTime), TMAX);

    // Async reset mid-race after P1 has one lap
    setPos(0, 300, 125); runCycles(2);
    setPos(0, 15, 117);  runCycles(2);
    checkOutput("lapBeforeReset", int'(p1Lap), 1);
    asyncReset();
    checkOutput("stateAfterReset", int'(state), 0);

    // Randomized driving against the model
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < 2; p++) if ($urandom_range(0, 5) == 0) pickPoint(p);
      if ($urandom_range(0, 999) == 0) asyncReset();
      else applyStimulus($urandom_range(0, 15) == 0);
    end

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule

// File: doc/race_state_controller.md
Name: race_state_controller

Overview:
- Upstream game-flow FSM for the two-player racer. It produces the 3-bit game state consumed by the operation encoder, both physics engines and the renderer, replacing the constant RACING value those blocks currently receive.
- It runs the start countdown and counts laps from each cart's world position via checkpoint and finish-line regions. It declares the winner and keeps a race timer for the HUD.

Parameters:
- TICK_CYCLES, 100000000: clk cycles per game tick (1 s at 100 MHz); minimum 2.
- LAPS_TO_WIN, 3: laps needed to finish; range 1..7.
- FIN_X0, 10'd5 / FIN_X1, 10'd40 / FIN_Y0, 10'd115 / FIN_Y1, 10'd120: inclusive finish-line box, world coordinates.
- CHK_X0, 10'd280 / CHK_X1, 10'd315 / CHK_Y0, 10'd115 / CHK_Y1, 10'd135: inclusive half-lap checkpoint box.
- TIME_MAX, 10'd999: race-timer saturation value.

Ports:
- clk  in  1  system clock (100 MHz)
- rst  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse (debounced/onepulsed upstream)
- p1_pos_x  in  10  P1 world x
- p1_pos_y  in  10  P1 world y
- p2_pos_x  in  10  P2 world x
- p2_pos_y  in  10  P2 world y
- state  out  3  game state (encoding below)
- countdown  out  2  seconds remaining in COUNT (3..1), else 0
- p1_lap  out  3  completed laps, P1
- p2_lap  out  3  completed laps, P2
- race_time  out  10  whole ticks elapsed in RACING, saturating
- state_changed  out  1  one-cycle pulse on every state transition

Behaviour:
- Encoding: IDLE=0, COUNT=1, GO=2, RACING=4, P1_WIN=5, P2_WIN=6, DRAW=7. Code 3 is illegal and goes to IDLE on the next clk.
- Reset (rst=0, async) values: state=IDLE, countdown=0, laps=0, race_time=0, state_changed=0, tick counter=0, armed flags=0, in-box history=0.
- Tick counter:
  - Counts 0..TICK_CYCLES-1 and cleared on every state entry.
  - tick is high for the cycle the counter equals TICK_CYCLES-1; the counter wraps to 0 on the next cycle.
- IDLE:
  - Laps, race_time and armed flags are held at 0.
  - start=1 -> COUNT with countdown=3.
- COUNT: on tick, countdown decrements. A tick while countdown=1 -> GO with countdown=0. start is ignored.
- GO: lasts exactly one tick, then -> RACING. start is ignored.
- RACING:
  - Positions are registered one stage before comparison, giving 1-cycle latency from position input to lap increment.
  - in_chk/in_fin: inclusive box tests on the registered positions.
  - Entering the checkpoint (rising edge of in_chk) sets armed_px.
  - Rising edge of in_fin while armed_px=1: p*_lap+1 and armed_px cleared.
  - Rising edge of in_fin while unarmed: no effect. This blocks reversing over the line and prevents counting the start position.
  - A player standing in the box does not re-count; only edges count.
  - race_time +1 per tick, holding at TIME_MAX.
  - start is ignored.
- Finish:
  - The cycle a lap count reaches LAPS_TO_WIN, the next state is P1_WIN or P2_WIN.
  - Both players reaching LAPS_TO_WIN on the same cycle -> DRAW.
  - Laps and race_time freeze on leaving RACING.
- P1_WIN, P2_WIN, DRAW: outputs are held. start -> IDLE, which clears laps and race_time on entry.
- state_changed pulses the cycle after the state register changes, aligned with the new state.
- Reset asserted mid-race returns to IDLE immediately (asynchronously). There is no partial lap retention.
- Width rules:
  - Lap counters cannot exceed LAPS_TO_WIN, so no wrap is possible.
  - Box comparisons are unsigned 10-bit.

Test Plan:
- Countdown (TICK_CYCLES=4): reset, pulse start -> state=1 with countdown=3, 2, 1 at 4-cycle intervals -> state=2 for 4 cycles -> state=4; state_changed pulses at each transition.
- Lap gating (LAPS_TO_WIN=2): P1 starts at (15,117) inside the finish box. Move out and back in -> p1_lap stays 0. Drive to (300,125), then (15,117) -> p1_lap=1 one cycle after the position update.
- P2 wins: P2 completes 2 valid laps while P1 has 1 -> state=6. p2_lap=2 and race_time are frozen on later ticks. A start pulse -> state=0 with laps=0.
- Draw: both players enter the finish box armed on the same cycle, each at lap 1 with LAPS_TO_WIN=2 -> state=7.
- Timer saturation (TIME_MAX=5): stay in RACING for 8 ticks -> race_time=5 and held.
- Async reset mid-race: drop rst between clk edges with p1_lap=1 -> state=0 and all outputs 0 immediately, without waiting for a clk edge. start pulses in COUNT and RACING produce no state change.
